// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester ids and counter widths
// for the instruction/data memory-port arbiter.
package mem_arb_pkg;
   typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;
   typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} req_id_t;
   localparam int LAT_W = 3;
   localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-over-fetch winner select with a saturating
// starvation counter that hands the port to a waiting fetch.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)(
   input  logic clock,
   input  logic reset,
   input  logic arb_en,
   input  logic i_req,
   input  logic d_req,
   output logic i_win,
   output logic d_win
);
   logic [STARVE_W-1:0] starve, starve_next;
   logic guard;
   always_comb begin
      guard = (STARVE_LIMIT != 0) && (starve == STARVE_W'(STARVE_LIMIT)) && i_req;
      i_win = arb_en && i_req && (!d_req || guard);
      d_win = arb_en && d_req && !guard;
      starve_next = starve;
      // a data grant in the else branch implies i_req is high
      if (arb_en && (i_win || !i_req)) starve_next = '0;
      else if (d_win && starve != STARVE_W'(STARVE_LIMIT)) starve_next = starve + 1'b1;
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) starve <= '0;
      else starve <= starve_next;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// fetch and data paths; reads block the port for LATENCY cycles.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int LATENCY      = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  m_en,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   output logic                  busy
);
   state_t state, state_next;
   req_id_t owner, owner_next;
   logic [LAT_W-1:0] lat_cnt, lat_next;
   logic [DATA_WIDTH-1:0] i_hold, d_hold;
   logic arb_en, i_win, d_win, rd_done;

   // grants are combinational, so they must be masked while reset is held
   assign arb_en = reset && (state == IDLE);
   assign busy = (state == RD_WAIT);

   mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
      .clock (clock),
      .reset (reset),
      .arb_en(arb_en),
      .i_req (i_req),
      .d_req (d_req),
      .i_win (i_win),
      .d_win (d_win)
   );

   always_comb begin
      state_next = state;
      owner_next = owner;
      lat_next = lat_cnt;
      rd_done = (state == RD_WAIT) && (lat_cnt == LAT_W'(1));
      i_gnt = i_win;
      d_gnt = d_win;
      m_en = i_win || d_win;
      m_we = d_win && d_we;
      m_addr = d_win ? d_addr : i_addr;
      m_wdata = d_wdata;
      if (state == IDLE) begin
         if (i_win || (d_win && !d_we)) begin
            state_next = RD_WAIT;
            owner_next = d_win ? REQ_D : REQ_I;
            lat_next = LAT_W'(LATENCY);
         end
      end else begin
         lat_next = lat_cnt - 1'b1;
         if (rd_done) state_next = IDLE;
      end
      i_rvalid = rd_done && (owner == REQ_I);
      d_rvalid = rd_done && (owner == REQ_D);
      i_rdata = i_rvalid ? m_rdata : i_hold;
      d_rdata = d_rvalid ? m_rdata : d_hold;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= IDLE;
         owner <= REQ_I;
         lat_cnt <= '0;
         i_hold <= '0;
         d_hold <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         lat_cnt <= lat_next;
         if (i_rvalid) i_hold <= m_rdata;
         if (d_rvalid) d_hold <= m_rdata;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of two arbiter
// configurations against a cycle-count reference model and RAM models.
module tb_mem_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int LAT_A = 2;
   localparam int LIM_A = 2;
   localparam int LAT_B = 3;
   localparam int LIM_B = 0;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   logic a_i_req = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
   logic [AW-1:0] a_i_addr = '0, a_d_addr = '0;
   logic [DW-1:0] a_d_wdata = '0;
   logic a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_en, a_m_we, a_busy;
   logic [DW-1:0] a_i_rdata, a_d_rdata, a_m_wdata, a_m_rdata;
   logic [AW-1:0] a_m_addr;

   logic b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
   logic [AW-1:0] b_i_addr = '0, b_d_addr = '0;
   logic [DW-1:0] b_d_wdata = '0;
   logic b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_en, b_m_we, b_busy;
   logic [DW-1:0] b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
   logic [AW-1:0] b_m_addr;

   // expected contents of addresses 0..15 of RAM A, and expected holding values
   logic [DW-1:0] ref_a [0:15];
   bit known_a [0:15];
   logic [DW-1:0] a_hold_i = '0, a_hold_d = '0;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT_A), .STARVE_LIMIT(LIM_A)) dut_a (
      .clock(clock), .reset(reset),
      .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
      .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata),
      .busy(a_busy)
   );

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT_B), .STARVE_LIMIT(LIM_B)) dut_b (
      .clock(clock), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata),
      .busy(b_busy)
   );

   // synchronous RAMs with a LATENCY-deep read pipeline
   logic [DW-1:0] mem_a [0:4095];
   logic [DW-1:0] pipe_a [0:LAT_A-1];
   always @(posedge clock) begin
      if (a_m_en && a_m_we) mem_a[a_m_addr] <= a_m_wdata;
      pipe_a[0] <= (a_m_en && !a_m_we) ? mem_a[a_m_addr] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
   end
   assign a_m_rdata = pipe_a[LAT_A-1];

   logic [DW-1:0] mem_b [0:4095];
   logic [DW-1:0] pipe_b [0:LAT_B-1];
   always @(posedge clock) begin
      if (b_m_en && b_m_we) mem_b[b_m_addr] <= b_m_wdata;
      pipe_b[0] <= (b_m_en && !b_m_we) ? mem_b[b_m_addr] : 32'hBAD1_BAD1;
      for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
   end
   assign b_m_rdata = pipe_b[LAT_B-1];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      a_i_req = 1'b1; a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = '0; a_d_wdata = 32'h5A5A_0001;
      b_i_req = 1'b1; b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = '0; b_d_wdata = 32'h5A5A_0002;
      repeat (3) begin
         @(negedge clock);
         total++;
         if ({a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_m_en, a_m_we, a_busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_a_ctrl got %b want 0000000", {a_i_gnt, a_d_gnt, a_i_rvalid, a_d_rvalid, a_m_en, a_m_we, a_busy});
         end
         total++;
         if ({b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid, b_m_en, b_m_we, b_busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_b_ctrl got %b want 0000000", {b_i_gnt, b_d_gnt, b_i_rvalid, b_d_rvalid, b_m_en, b_m_we, b_busy});
         end
         total++;
         if (a_i_rdata !== '0 || a_d_rdata !== '0 || b_i_rdata !== '0 || b_d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_rdata got %h %h %h %h want 0", a_i_rdata, a_d_rdata, b_i_rdata, b_d_rdata);
         end
      end
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      total++;
      if (a_d_gnt !== 1'b1 || a_i_gnt !== 1'b0 || a_m_en !== 1'b1 || a_m_we !== 1'b1) begin
         bad++;
         $display("FAIL release_a got d=%b i=%b en=%b we=%b want 1 0 1 1", a_d_gnt, a_i_gnt, a_m_en, a_m_we);
      end
      total++;
      if (b_d_gnt !== 1'b1 || b_i_gnt !== 1'b0) begin
         bad++;
         $display("FAIL release_b got d=%b i=%b want 1 0", b_d_gnt, b_i_gnt);
      end
      ref_a[0] = 32'h5A5A_0001;
      known_a[0] = 1'b1;
      tick();
      a_i_req = 1'b0; a_d_req = 1'b0;
      b_i_req = 1'b0; b_d_req = 1'b0;
      tick();
   endtask

   task automatic test_fetch_read();
      a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 12'h010; a_d_wdata = 32'h0000_ABCD;
      @(negedge clock);
      total++;
      if (a_d_gnt !== 1'b1) begin bad++; $display("FAIL fetch_preload_gnt got %b want 1", a_d_gnt); end
      tick();
      a_d_req = 1'b0; a_i_req = 1'b1; a_i_addr = 12'h010;
      @(negedge clock);
      total++;
      if (a_i_gnt !== 1'b1 || a_busy !== 1'b0 || a_m_we !== 1'b0 || a_m_addr !== 12'h010) begin
         bad++;
         $display("FAIL fetch_T got gnt=%b busy=%b we=%b addr=%h want 1 0 0 010", a_i_gnt, a_busy, a_m_we, a_m_addr);
      end
      tick();
      a_i_req = 1'b0;
      @(negedge clock);
      total++;
      if (a_busy !== 1'b1 || a_i_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL fetch_T1 got busy=%b rvalid=%b want 1 0", a_busy, a_i_rvalid);
      end
      tick();
      @(negedge clock);
      total++;
      if (a_busy !== 1'b1 || a_i_rvalid !== 1'b1 || a_i_rdata !== 32'h0000_ABCD) begin
         bad++;
         $display("FAIL fetch_T2 got busy=%b rvalid=%b data=%h want 1 1 0000abcd", a_busy, a_i_rvalid, a_i_rdata);
      end
      a_hold_i = 32'h0000_ABCD;
      tick();
      @(negedge clock);
      total++;
      if (a_busy !== 1'b0 || a_i_rvalid !== 1'b0 || a_i_rdata !== 32'h0000_ABCD) begin
         bad++;
         $display("FAIL fetch_hold got busy=%b rvalid=%b data=%h want 0 0 0000abcd", a_busy, a_i_rvalid, a_i_rdata);
      end
      tick();
   endtask

   task automatic test_write_readback();
      a_d_req = 1'b1; a_d_we = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         a_d_addr = AW'(k);
         a_d_wdata = DW'(k * 32'h11);
         @(negedge clock);
         total++;
         if (a_d_gnt !== 1'b1 || a_m_we !== 1'b1 || a_m_addr !== AW'(k) || a_m_wdata !== DW'(k * 32'h11)) begin
            bad++;
            $display("FAIL wr_b2b k=%0d got gnt=%b we=%b addr=%h data=%h", k, a_d_gnt, a_m_we, a_m_addr, a_m_wdata);
         end
         ref_a[k] = DW'(k * 32'h11);
         known_a[k] = 1'b1;
         tick();
      end
      a_d_we = 1'b0; a_d_addr = 12'h002;
      @(negedge clock);
      total++;
      if (a_d_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got %b want 1", a_d_gnt); end
      tick();
      a_d_req = 1'b0;
      @(negedge clock);
      total++;
      if (a_d_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early got %b want 0", a_d_rvalid); end
      tick();
      @(negedge clock);
      total++;
      if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'h22) begin
         bad++;
         $display("FAIL rd_back got rvalid=%b data=%h want 1 00000022", a_d_rvalid, a_d_rdata);
      end
      a_hold_d = 32'h22;
      tick();
   endtask

   task automatic test_starvation();
      bit seq [0:5];
      bit exp_seq [0:5];
      int n = 0;
      exp_seq = '{0, 0, 1, 0, 0, 1};
      a_i_req = 1'b1; a_i_addr = 12'h002;
      a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 12'h100; a_d_wdata = 32'hC0DE_0000;
      for (int c = 0; c < 40 && n < 6; c++) begin
         @(negedge clock);
         if (a_i_gnt === 1'b1 && a_d_gnt === 1'b1) begin
            bad++;
            $display("FAIL starve_dual c=%0d both grants high", c);
         end
         if (a_i_gnt === 1'b1) begin seq[n] = 1'b1; n++; end
         else if (a_d_gnt === 1'b1) begin seq[n] = 1'b0; n++; end
         tick();
         a_d_addr = a_d_addr + 1'b1;
         a_d_wdata = a_d_wdata + 1'b1;
      end
      a_i_req = 1'b0; a_d_req = 1'b0;
      total++;
      if (n != 6) begin
         bad++;
         $display("FAIL starve_budget got %0d grants want 6", n);
      end
      for (int k = 0; k < n; k++) begin
         total++;
         if (seq[k] !== exp_seq[k]) begin
            bad++;
            $display("FAIL starve_order slot=%0d got %s want %s", k, seq[k] ? "I" : "D", exp_seq[k] ? "I" : "D");
         end
      end
      repeat (4) tick();
      a_hold_i = 32'h22;
      @(negedge clock);
      total++;
      if (a_i_rdata !== 32'h22) begin bad++; $display("FAIL starve_fetch_data got %h want 00000022", a_i_rdata); end
      tick();
   endtask

   task automatic test_starve_off();
      b_i_req = 1'b1; b_i_addr = 12'h000;
      b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 12'h100; b_d_wdata = 32'hFEED_0000;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         total++;
         if (b_i_gnt !== 1'b0 || b_d_gnt !== 1'b1) begin
            bad++;
            $display("FAIL nostarve c=%0d got i=%b d=%b want 0 1", c, b_i_gnt, b_d_gnt);
         end
         tick();
         b_d_addr = b_d_addr + 1'b1;
      end
      b_d_req = 1'b0;
      @(negedge clock);
      total++;
      if (b_i_gnt !== 1'b1) begin bad++; $display("FAIL nostarve_release got %b want 1", b_i_gnt); end
      tick();
      b_i_req = 1'b0;
      repeat (2) tick();
      @(negedge clock);
      total++;
      if (b_i_rvalid !== 1'b1 || b_i_rdata !== 32'h5A5A_0002) begin
         bad++;
         $display("FAIL nostarve_data got rvalid=%b data=%h want 1 5a5a0002", b_i_rvalid, b_i_rdata);
      end
      tick();
   endtask

   // reference: one read in flight, ports free again LAT_A+1 cycles after a read grant
   task automatic test_random();
      int free_at = 0;
      int starve = 0;
      int rcyc = -1;
      bit rport = 1'b0;
      logic [DW-1:0] rexp = '0;
      bit ip = 1'b0, dp = 1'b0, ireq, idle, guard, ei, ed, evi, evd;
      for (int c = 0; c < 400; c++) begin
         if (!ip && $urandom_range(0, 2) != 0) begin
            ip = 1'b1;
            do a_i_addr = AW'($urandom_range(0, 15)); while (!known_a[a_i_addr[3:0]]);
         end
         if (!dp && $urandom_range(0, 2) != 0) begin
            dp = 1'b1;
            a_d_addr = AW'($urandom_range(0, 15));
            a_d_we = ($urandom_range(0, 1) == 1) || !known_a[a_d_addr[3:0]];
            a_d_wdata = $urandom;
         end
         a_i_req = ip; a_d_req = dp;
         ireq = ip;
         @(negedge clock);
         idle = (c >= free_at);
         guard = idle && (LIM_A != 0) && (starve == LIM_A) && ip;
         ei = idle && ip && (!dp || guard);
         ed = idle && dp && !guard;
         evi = (rcyc == c) && !rport;
         evd = (rcyc == c) && rport;
         if (evi) a_hold_i = rexp;
         if (evd) a_hold_d = rexp;
         total++;
         if (a_i_gnt !== ei || a_d_gnt !== ed) begin
            bad++;
            $display("FAIL rand_gnt c=%0d got i=%b d=%b want i=%b d=%b", c, a_i_gnt, a_d_gnt, ei, ed);
         end
         total++;
         if (a_busy !== !idle) begin bad++; $display("FAIL rand_busy c=%0d got %b want %b", c, a_busy, !idle); end
         total++;
         if (a_i_rvalid !== evi || a_d_rvalid !== evd) begin
            bad++;
            $display("FAIL rand_rvalid c=%0d got i=%b d=%b want i=%b d=%b", c, a_i_rvalid, a_d_rvalid, evi, evd);
         end
         total++;
         if (a_i_rdata !== a_hold_i || a_d_rdata !== a_hold_d) begin
            bad++;
            $display("FAIL rand_rdata c=%0d got i=%h d=%h want i=%h d=%h", c, a_i_rdata, a_d_rdata, a_hold_i, a_hold_d);
         end
         if (ei) begin
            ip = 1'b0;
            rcyc = c + LAT_A; rport = 1'b0; rexp = ref_a[a_i_addr[3:0]]; free_at = c + LAT_A + 1;
         end
         if (ed) begin
            dp = 1'b0;
            if (a_d_we) begin
               ref_a[a_d_addr[3:0]] = a_d_wdata;
               known_a[a_d_addr[3:0]] = 1'b1;
            end else begin
               rcyc = c + LAT_A; rport = 1'b1; rexp = ref_a[a_d_addr[3:0]]; free_at = c + LAT_A + 1;
            end
         end
         if (ei || (idle && !ireq)) starve = 0;
         else if (ed && ireq && starve < LIM_A) starve++;
         tick();
      end
      a_i_req = 1'b0; a_d_req = 1'b0;
      repeat (LAT_A + 1) tick();
   endtask

   task automatic test_reset_mid_read();
      b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 12'h000;
      @(negedge clock);
      total++;
      if (b_d_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt got %b want 1", b_d_gnt); end
      tick();
      b_d_req = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      total++;
      if (b_busy !== 1'b0 || b_d_rvalid !== 1'b0 || b_i_rdata !== '0) begin
         bad++;
         $display("FAIL midrst_clear got busy=%b rvalid=%b idata=%h want 0 0 0", b_busy, b_d_rvalid, b_i_rdata);
      end
      tick();
      reset = 1'b1;
      b_i_req = 1'b1; b_i_addr = 12'h000;
      @(negedge clock);
      total++;
      if (b_i_gnt !== 1'b1 || b_d_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL midrst_regrant got gnt=%b rvalid=%b want 1 0", b_i_gnt, b_d_rvalid);
      end
      tick();
      b_i_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         total++;
         if (b_d_rvalid !== 1'b0 || b_i_rvalid !== 1'b0 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_stale k=%0d got drv=%b irv=%b busy=%b want 0 0 1", k, b_d_rvalid, b_i_rvalid, b_busy);
         end
         tick();
      end
      @(negedge clock);
      total++;
      if (b_i_rvalid !== 1'b1 || b_i_rdata !== 32'h5A5A_0002 || b_d_rdata !== '0) begin
         bad++;
         $display("FAIL midrst_newread got rv=%b idata=%h ddata=%h want 1 5a5a0002 0", b_i_rvalid, b_i_rdata, b_d_rdata);
      end
      tick();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         ref_a[k] = '0;
         known_a[k] = 1'b0;
      end
      test_reset();
      test_fetch_read();
      test_write_readback();
      test_starvation();
      test_starve_off();
      test_random();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised memory-port arbiter letting the processor's instruction-fetch and data-access paths share one single-port synchronous RAM. It replaces the fixed split ROM/RAM pair in the top-level wrapper with a unified memory behind request/grant handshakes. Data accesses have priority over fetches; a programmable starvation guard bounds fetch wait time. It has configurable width, depth and memory read latency.

## Interface
- `ADDR_WIDTH`, 12: word-address width; memory depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `LATENCY`, 1: backend read latency in cycles (legal 1..4).
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch waits (legal 0..15); 0 disables the guard.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = in reset.
- `i_req`  in  1  fetch request; held until granted.
- `i_addr`  in  ADDR_WIDTH  fetch address; stable while `i_req` is high.
- `i_gnt`  out  1  fetch accepted this cycle.
- `i_rvalid`  out  1  fetch data valid this cycle.
- `i_rdata`  out  DATA_WIDTH  fetch data.
- `d_req`  in  1  data request; held until granted.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid this cycle.
- `d_rdata`  out  DATA_WIDTH  load data.
- `m_en`  out  1  memory access strobe.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  ADDR_WIDTH  memory address.
- `m_wdata`  out  DATA_WIDTH  memory write data.
- `m_rdata`  in  DATA_WIDTH  memory read data, valid LATENCY cycles after the `m_en` cycle.
- `busy`  out  1  high while a read is outstanding.

## Operation
- FSM has two states: IDLE and RD_WAIT.
- **IDLE:** when any request is pending, pick a winner.
  - Assert its `x_gnt` combinationally in the same cycle.
  - Drive `m_en`=1, `m_we`, `m_addr` and `m_wdata` from the winner's inputs in that cycle. `m_we`=0 for fetches.
  - A write completes at grant; the FSM stays in IDLE, so back-to-back writes run one per cycle.
  - A read loads the latency counter with LATENCY and moves to RD_WAIT, recording the requester id.
- **RD_WAIT:**
  - No grants; `m_en`=0.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1, the recorded requester's `x_rvalid`=1 and `x_rdata`=`m_rdata` (pass-through). The value is also captured into that port's holding register.
  - The next state is IDLE.
- **Priority:** data wins over fetch. Exception: when the starvation counter equals STARVE_LIMIT (and STARVE_LIMIT≠0) and `i_req`=1, the fetch wins.
- **Starvation counter:**
  - Increments on each data grant made while `i_req`=1.
  - Clears on a fetch grant, and on any cycle in IDLE with `i_req`=0.
  - Saturates at STARVE_LIMIT.
- **`x_rdata` outside its rvalid cycle:** holds the last value captured for that port.
- **`busy`:** equals (state == RD_WAIT).
- **Requesters:** must keep req, address and data stable until gnt. Dropping `x_req` before gnt is legal (the request is withdrawn).

## Timing
- Reset values: state IDLE, counters 0, holding registers 0. All gnt/rvalid/`m_en`/`m_we`/`busy` outputs read 0.
- Read issued in cycle T: `x_rvalid` high in cycle T+LATENCY. The earliest next grant is cycle T+LATENCY+1.
- Read throughput is 1 per LATENCY+1 cycles. Write throughput is 1 per cycle.
- Simultaneous `i_req` and `d_req` in IDLE: `d_gnt` only, unless the guard fires.
- Requests arriving during RD_WAIT wait. They are evaluated in the first IDLE cycle.
- Reset asserted mid-read: the outstanding response is discarded and no rvalid is issued. After release, the FSM is in IDLE.
- The address space wraps naturally at 2^ADDR_WIDTH; no range check.

## Structure
- Package `mem_arb_pkg`:
  - state encoding (IDLE, RD_WAIT);
  - requester-id constants (REQ_I, REQ_D);
  - latency-counter width (3 bits) and starvation-counter width (4 bits).
- Sub-module `mem_arb_prio` holds the winner-select logic and the starvation counter. The top level holds the FSM, the latency counter and the response holding registers.

## Test plan
- **Reset:** `reset`=0 with `i_req`=`d_req`=1. Required: all gnt/rvalid/`m_en` stay 0 and `i_rdata`/`d_rdata`=0. On release, `d_gnt` comes in the first cycle.
- **Fetch read, LATENCY=2:** memory word 0x010 = 0x0000_ABCD, fetch `i_addr`=0x010. Required: `i_gnt` in T, `busy` in T+1..T+2, `i_rvalid`=1 with `i_rdata`=0x0000_ABCD in T+2. `i_rdata` holds that value afterwards.
- **Write/read-back:** three back-to-back writes to 0x001..0x003 with data 0x11/0x22/0x33. Required: `d_gnt` in 3 consecutive cycles. A read of 0x002 then returns 0x22.
- **Starvation, STARVE_LIMIT=2:** `d_req` continuously asserted (writes) with `i_req`=1. Required: grant order D, D, I, D, D, I.
- **Starvation disabled, STARVE_LIMIT=0:** same stimulus. Required: no `i_gnt` while `d_req`=1.
- **Reset mid-read:** read issued, then reset pulsed low in T+1 (LATENCY=3). Required: no rvalid at T+3, `busy`=0 immediately, and a new request is granted on the first cycle after release.
